// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: valid/ready handshake with a 2-entry skid buffer,
// flush squash and saturating stall/bubble counters.
module pipe_stage_elastic #(
  parameter int CTRL_W              = 8,
  parameter int DATA_W              = 256,
  parameter bit CLEAR_DATA_ON_FLUSH = 1'b0,
  parameter int CNT_W               = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  bubble_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;
  logic [CNT_W-1:0]  bubble_count_q, bubble_count_d;

  logic accept;
  logic out_fire;

  // Ready comes only from the state register, never from out_ready.
  assign in_ready     = (state_q != FULL);
  assign out_valid    = (state_q != EMPTY);
  assign out_ctrl     = out_valid ? main_ctrl_q : '0;
  assign out_data     = main_data_q;
  assign occupancy    = state_q;
  assign stall_count  = stall_count_q;
  assign bubble_count = bubble_count_q;

  assign accept   = in_valid & in_ready & ~flush;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d     = EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      if (CLEAR_DATA_ON_FLUSH) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d     = ONE;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        ONE: begin
          if (accept && out_fire) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (accept) begin
            state_d     = FULL;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d     = ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_count_d  = stall_count_q;
    bubble_count_d = bubble_count_q;
    if (out_valid && !out_ready && stall_count_q != '1)
      stall_count_d = stall_count_q + CNT_W'(1);
    if (!out_valid && out_ready && bubble_count_q != '1)
      bubble_count_d = bubble_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= EMPTY;
      main_ctrl_q    <= '0;
      main_data_q    <= '0;
      skid_ctrl_q    <= '0;
      skid_data_q    <= '0;
      stall_count_q  <= '0;
      bubble_count_q <= '0;
    end else begin
      state_q        <= state_d;
      main_ctrl_q    <= main_ctrl_d;
      main_data_q    <= main_data_d;
      skid_ctrl_q    <= skid_ctrl_d;
      skid_data_q    <= skid_data_d;
      stall_count_q  <= stall_count_d;
      bubble_count_q <= bubble_count_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_pipe_stage_elastic;

  localparam int CW = 8;
  localparam int DW = 32;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [NW-1:0] stall_count;
  logic [NW-1:0] bubble_count;

  pipe_stage_elastic #(
    .CTRL_W(CW),
    .DATA_W(DW),
    .CLEAR_DATA_ON_FLUSH(1'b0),
    .CNT_W(NW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_ctrl(in_ctrl),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl(out_ctrl),
    .out_data(out_data),
    .occupancy(occupancy),
    .stall_count(stall_count),
    .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference: FIFO of {ctrl,data}, capacity 2.
  logic [CW+DW-1:0] mq[$];
  logic [DW-1:0]    m_last;
  int               m_stall;
  int               m_bubble;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_last   = '0;
    m_stall  = 0;
    m_bubble = 0;
  endtask

  task automatic check_all();
    int sz;
    sz = mq.size();
    chk("out_valid", 64'(out_valid), 64'(sz > 0));
    chk("out_ctrl", 64'(out_ctrl), sz > 0 ? 64'(mq[0][DW+:CW]) : 64'd0);
    chk("out_data", 64'(out_data), 64'(m_last));
    chk("occupancy", 64'(occupancy), 64'(sz));
    chk("in_ready", 64'(in_ready), 64'(sz < 2));
    chk("stall_count", 64'(stall_count), 64'(m_stall));
    chk("bubble_count", 64'(bubble_count), 64'(m_bubble));
  endtask

  task automatic tick();
    bit acc;
    bit fire;
    int sz;
    @(posedge clk);
    sz   = mq.size();
    acc  = in_valid && (sz < 2) && !flush;
    fire = (sz > 0) && out_ready;
    if (sz > 0 && !out_ready && m_stall < (1 << NW) - 1) m_stall++;
    if (sz == 0 && out_ready && m_bubble < (1 << NW) - 1) m_bubble++;
    if (flush) begin
      mq.delete();
    end else begin
      if (fire) void'(mq.pop_front());
      if (acc) mq.push_back({in_ctrl, in_data});
      if (mq.size() > 0) m_last = mq[0][DW-1:0];
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input bit v, input logic [CW-1:0] c,
                       input logic [DW-1:0] d, input bit r, input bit f);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, '0, '0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_all();

    // single beat
    drive(1, 8'h15, 32'hABC, 1, 0);
    tick();
    chk("first_ctrl", 64'(out_ctrl), 64'h15);
    chk("first_data", 64'(out_data), 64'hABC);
    drive(0, '0, '0, 1, 0);
    tick();

    // back-to-back stream
    for (int i = 0; i < 10; i++) begin
      drive(1, CW'(i + 1), DW'(32'h1000 + i), 1, 0);
      tick();
      chk("stream_data", 64'(out_data), 64'(32'h1000 + i));
    end
    drive(0, '0, '0, 1, 0);
    tick();

    // back-pressure: A, B, then C refused while full
    drive(1, 8'hA1, 32'hAAAA, 0, 0);
    tick();
    drive(1, 8'hB2, 32'hBBBB, 0, 0);
    tick();
    drive(1, 8'hC3, 32'hCCCC, 0, 0);
    tick();
    tick();
    chk("hold_a", 64'(out_data), 64'hAAAA);
    for (int k = 0; k < 8; k++) begin
      bit will_acc;
      will_acc = mq.size() < 2;
      drive(1, 8'hC3, 32'hCCCC, 1, 0);
      tick();
      if (will_acc) break;
    end
    drive(0, '0, '0, 1, 0);
    repeat (3) tick();

    // flush while full drops the presented beat, keeps data
    drive(1, 8'h11, 32'h1111, 0, 0);
    tick();
    drive(1, 8'h22, 32'h2222, 0, 0);
    tick();
    drive(1, 8'h33, 32'h3333, 1, 1);
    tick();
    chk("flush_data", 64'(out_data), 64'h1111);
    drive(0, '0, '0, 1, 0);
    repeat (2) tick();

    // asynchronous reset while full
    drive(1, 8'h44, 32'h4444, 0, 0);
    tick();
    drive(1, 8'h55, 32'h5555, 0, 0);
    tick();
    drive(0, '0, '0, 0, 0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_occ", 64'(occupancy), 64'd0);
    chk("arst_ready", 64'(in_ready), 64'd1);
    chk("arst_data", 64'(out_data), 64'd0);
    chk("arst_stall", 64'(stall_count), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    check_all();

    // stall counter saturation
    drive(1, 8'h66, 32'h6666, 0, 0);
    tick();
    drive(0, '0, '0, 0, 0);
    repeat ((1 << NW) + 5) tick();
    chk("stall_sat", 64'(stall_count), 64'hF);
    drive(0, '0, '0, 1, 0);
    repeat (2) tick();

    // random traffic
    for (int i = 0; i < 500; i++) begin
      drive(bit'($urandom_range(0, 3) != 0), CW'($urandom),
            DW'($urandom), bit'($urandom_range(0, 9) < 7),
            bit'($urandom_range(0, 19) == 0));
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1);
  end

endmodule
